// File: rtl/interp_pkg.sv
// Shared constants and state encoding for the x4 interpolator.
package interp_pkg;

  localparam int unsigned FACTOR        = 4;
  localparam int unsigned SHIFT         = $clog2(FACTOR);
  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned K_W           = 3;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t EMIT = 1'b1;

endpackage

// File: rtl/interp_lerp.sv
// Combinational linear blend: ((FACTOR-k)*p + k*n) >>> SHIFT, computed in
// WIDTH+2 bits so the weighted sum cannot overflow; result rounds toward -inf.
module interp_lerp
  import interp_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [WIDTH-1:0] p,
  input  logic signed [WIDTH-1:0] n,
  input  logic        [K_W-1:0]   k,
  output logic signed [WIDTH-1:0] y
);

  localparam int unsigned SW = WIDTH + 2;

  logic signed [SW-1:0] p_x;
  logic signed [SW-1:0] n_x;
  logic signed [SW-1:0] wk;
  logic signed [SW-1:0] wp;
  logic signed [SW-1:0] sum;

  // Sign-extend, weight and shift
  always_comb begin
    p_x = SW'(p);
    n_x = SW'(n);
    wk  = $signed(SW'(k));
    wp  = $signed(SW'(FACTOR)) - wk;
    sum = (wp * p_x) + (wk * n_x);
    y   = WIDTH'(sum >>> SHIFT);
  end

endmodule

// File: rtl/interpolator_x4.sv
// 1:4 upsampler with valid/ready handshakes on both sides.
// Build option: define INTERPOLATOR_X4_HOLD_EN for zero-order hold (all four
// outputs equal the new sample, no interpolation arithmetic).
module interpolator_x4
  import interp_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  state_t                  state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic signed [WIDTH-1:0] p_q, p_d;
  logic signed [WIDTH-1:0] n_q, n_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic                    valid_q;
  logic signed [WIDTH-1:0] next_n;
  logic signed [WIDTH-1:0] next_y;

  // Sample feeding the next output: the arriving one in IDLE, the latched one in EMIT
  assign next_n = (state_q == IDLE) ? in_data : n_q;

`ifdef INTERPOLATOR_X4_HOLD_EN
  assign next_y = next_n;
`else
  logic [K_W-1:0] next_k;

  // Phase of the output being prepared for the following cycle
  assign next_k = (state_q == IDLE) ? K_W'(1) : k_q + K_W'(1);

  interp_lerp #(
    .WIDTH (WIDTH)
  ) u_lerp (
    .p (p_q),
    .n (next_n),
    .k (next_k),
    .y (next_y)
  );
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    n_d     = n_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d     = in_data;
          k_d     = K_W'(1);
          data_d  = next_y;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (k_q == K_W'(FACTOR)) begin
            state_d = IDLE;
            k_d     = K_W'(1);
            p_d     = n_q;
          end else begin
            k_d    = k_q + K_W'(1);
            data_d = next_y;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any sequence in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= K_W'(1);
      p_q     <= '0;
      n_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      n_q     <= n_d;
      data_q  <= data_d;
      valid_q <= (state_d == EMIT);
    end
  end

  // in_ready is masked by rst so no sample is taken during reset
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_interpolator_x4.sv
// Self-checking bench for interpolator_x4: directed cases plus randomized
// traffic against a queue-based reference model.
module tb_interpolator_x4;

  localparam int unsigned WIDTH = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int seen[$];
  int p_m = 0;

  interpolator_x4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected four outputs for a new sample n after previous sample p
  function automatic void push4(input int p, input int n);
    for (int k = 1; k <= 4; k++) begin
`ifdef INTERPOLATOR_X4_HOLD_EN
      exp_q.push_back(n);
`else
      exp_q.push_back(((4 - k) * p + k * n) >>> 2);
`endif
    end
  endfunction

  // One clock cycle: drive, check against model, then advance model
  task automatic step(input logic rv, input logic iv, input int id, input logic orr);
    logic exp_ir, exp_ov, acc_in, acc_out;
    int   n;
    @(negedge clk);
    rst       = rv;
    in_valid  = iv;
    in_data   = WIDTH'(id);
    out_ready = orr;
    #1;
    n      = int'(in_data);
    exp_ir = !rv && (exp_q.size() == 0);
    exp_ov = (exp_q.size() != 0);
    check("in_ready", int'(in_ready), int'(exp_ir));
    check("out_valid", int'(out_valid), int'(exp_ov));
    if (exp_ov) check("out_data", int'(out_data), exp_q[0]);
    acc_in  = iv && exp_ir;
    acc_out = orr && exp_ov && !rv;
    if (acc_out) seen.push_back(int'(out_data));
    @(posedge clk);
    if (rv) begin
      exp_q.delete();
      p_m = 0;
    end else if (acc_in) begin
      push4(p_m, n);
      p_m = n;
    end else if (acc_out) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic send(input int v);
    step(1'b0, 1'b1, v, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic expect_seen(input string tag, input int a, input int b, input int c, input int d);
    int want[4];
    want = '{a, b, c, d};
    if (seen.size() < 4) begin
      check({tag, "_count"}, seen.size(), 4);
    end else begin
      for (int i = 0; i < 4; i++)
        check(tag, seen[seen.size() - 4 + i], want[i]);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 123, 1'b1);
    @(negedge clk);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_valid", int'(out_valid), 0);

    // Ramp up, then down across zero
    send(100);
`ifndef INTERPOLATOR_X4_HOLD_EN
    expect_seen("ramp_up", 25, 50, 75, 100);
`endif
    send(-100);
`ifndef INTERPOLATOR_X4_HOLD_EN
    expect_seen("ramp_down", 50, 0, -50, -100);
`endif

    // Rounding toward minus infinity from a fresh reset
    step(1'b1, 1'b0, 0, 1'b1);
    send(1);
`ifndef INTERPOLATOR_X4_HOLD_EN
    expect_seen("round", 0, 0, 0, 1);
`endif

    // Full-scale swing must not overflow
    send(-32768);
    send(32767);
`ifndef INTERPOLATOR_X4_HOLD_EN
    expect_seen("extreme", -16385, -1, 16383, 32767);
`endif

    // Backpressure while the second output (50) is presented
    step(1'b1, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 100, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 999 + i, 1'b0);
`ifndef INTERPOLATOR_X4_HOLD_EN
      check("bp_hold", int'(out_data), 50);
`endif
      check("bp_in_ready", int'(in_ready), 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1);
`ifndef INTERPOLATOR_X4_HOLD_EN
    expect_seen("bp_resume", 25, 50, 75, 100);
`endif

    // Reset after the second output aborts the sequence
    step(1'b0, 1'b1, 200, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b1);
    @(negedge clk);
    check("abort_out_valid", int'(out_valid), 0);
    send(40);
`ifndef INTERPOLATOR_X4_HOLD_EN
    expect_seen("abort_restart", 10, 20, 30, 40);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom()),
           ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
